// File: rtl/timer_pkg.sv
// Shared encodings for the programmable timer: register control codes and FSM states.
package timer_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        INCR = 2'd1,
        LOAD = 2'd2,
        CLR  = 2'd3
    } reg_ctrl_t;

    typedef enum logic {
        COUNT = 1'b0,
        HALT  = 1'b1
    } state_t;

endpackage

// File: rtl/register.sv
// Generic W-bit state register with hold / increment / load / clear control.
import timer_pkg::*;

module register #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         async_nreset,
    input  reg_ctrl_t    ctrl,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            q <= '0;
        end else begin
            unique case (ctrl)
                INCR:    q <= q + W'(1);
                LOAD:    q <= d;
                CLR:     q <= '0;
                default: q <= q;
            endcase
        end
    end

endmodule

// File: rtl/prog_timer.sv
// Programmable interval timer: prescaled counter with periodic / one-shot modes,
// one-cycle expiry pulse and a sticky, acknowledgeable interrupt flag.
import timer_pkg::*;

module prog_timer #(
    parameter int               WIDTH           = 32,
    parameter int               PRESCALE_WIDTH  = 16,
    parameter logic [WIDTH-1:0] DEFAULT_PERIOD  = 3,
    parameter bit               DEFAULT_ONESHOT = 1'b0
) (
    input  logic                      clk,
    input  logic                      async_nreset,
    input  logic                      enable,
    input  logic                      clear,
    input  logic                      cfg_load,
    input  logic [WIDTH-1:0]          cfg_period,
    input  logic [PRESCALE_WIDTH-1:0] cfg_prescale,
    input  logic                      cfg_oneshot,
    input  logic                      irq_ack,
    output logic [WIDTH-1:0]          count,
    output logic                      at_terminal,
    output logic                      expired,
    output logic                      irq,
    output logic                      running
);

    logic [WIDTH-1:0]          period_reg;
    logic [PRESCALE_WIDTH-1:0] prescale_reg;
    logic [PRESCALE_WIDTH-1:0] presc_cnt;
    logic                      mode_reg;
    state_t                    state, state_nxt;
    reg_ctrl_t                 cnt_ctrl, presc_ctrl;
    logic                      restart, active, tick, terminal, expired_nxt;

    assign restart     = cfg_load || clear;
    assign active      = enable && (state == COUNT);
    assign tick        = active && (presc_cnt == prescale_reg);
    assign terminal    = (count == period_reg);
    assign at_terminal = terminal;
    assign running     = (state == COUNT);

    register #(.W(PRESCALE_WIDTH)) u_presc (
        .clk          (clk),
        .async_nreset (async_nreset),
        .ctrl         (presc_ctrl),
        .d            ('0),
        .q            (presc_cnt)
    );

    register #(.W(WIDTH)) u_count (
        .clk          (clk),
        .async_nreset (async_nreset),
        .ctrl         (cnt_ctrl),
        .d            ('0),
        .q            (count)
    );

    always_comb begin
        presc_ctrl = NONE;
        if (restart || tick) presc_ctrl = CLR;
        else if (active)     presc_ctrl = INCR;
    end

    // At terminal: periodic wraps to 0, one-shot holds (and halts below).
    always_comb begin
        cnt_ctrl = NONE;
        if (restart) begin
            cnt_ctrl = CLR;
        end else if (tick) begin
            if (!terminal)      cnt_ctrl = INCR;
            else if (!mode_reg) cnt_ctrl = CLR;
        end
    end

    // Pulse when a tick lands the count on the period; a period of 0 in
    // periodic mode pulses on every tick, the one-shot halt never does.
    always_comb begin
        expired_nxt = 1'b0;
        if (!restart && tick) begin
            if (terminal) expired_nxt = !mode_reg && (period_reg == '0);
            else          expired_nxt = ((count + WIDTH'(1)) == period_reg);
        end
    end

    always_comb begin
        state_nxt = state;
        if (restart)                         state_nxt = COUNT;
        else if (tick && terminal && mode_reg) state_nxt = HALT;
    end

    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) state <= COUNT;
        else               state <= state_nxt;
    end

    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            period_reg   <= DEFAULT_PERIOD;
            prescale_reg <= '0;
            mode_reg     <= DEFAULT_ONESHOT;
            expired      <= 1'b0;
            irq          <= 1'b0;
        end else begin
            if (cfg_load) begin
                period_reg   <= cfg_period;
                prescale_reg <= cfg_prescale;
                mode_reg     <= cfg_oneshot;
            end
            expired <= expired_nxt;
            if (expired_nxt)  irq <= 1'b1;
            else if (irq_ack) irq <= 1'b0;
        end
    end

endmodule

// File: tb/tb_prog_timer.sv
// Self-checking bench for prog_timer: cycle model compared every cycle plus directed literal checks.
module tb_prog_timer;

    localparam int W  = 8;
    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          async_nreset = 1'b0;
    logic          enable = 1'b0, clear = 1'b0, cfg_load = 1'b0, cfg_oneshot = 1'b0, irq_ack = 1'b0;
    logic [W-1:0]  cfg_period = '0;
    logic [PW-1:0] cfg_prescale = '0;
    logic [W-1:0]  count;
    logic          at_terminal, expired, irq, running;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    prog_timer #(
        .WIDTH(W), .PRESCALE_WIDTH(PW), .DEFAULT_PERIOD(3), .DEFAULT_ONESHOT(1'b0)
    ) dut (
        .clk(clk), .async_nreset(async_nreset), .enable(enable), .clear(clear),
        .cfg_load(cfg_load), .cfg_period(cfg_period), .cfg_prescale(cfg_prescale),
        .cfg_oneshot(cfg_oneshot), .irq_ack(irq_ack), .count(count),
        .at_terminal(at_terminal), .expired(expired), .irq(irq), .running(running)
    );

    typedef struct packed {
        logic [W-1:0]  count;
        logic [PW-1:0] presc;
        logic [W-1:0]  period;
        logic [PW-1:0] pscl;
        logic          oneshot;
        logic          halt;
        logic          exp;
        logic          irq;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t rst_state();
        mstate_t s;
        s = '0;
        s.period = 8'd3;
        return s;
    endfunction

    // One clock of the timer rules, applied to the model state.
    function automatic mstate_t step(input mstate_t s);
        mstate_t n;
        int      next_cnt;
        n = s;
        n.exp = 1'b0;
        if (cfg_load) begin
            n.period = cfg_period; n.pscl = cfg_prescale; n.oneshot = cfg_oneshot;
            n.count = '0; n.presc = '0; n.halt = 1'b0;
        end else if (clear) begin
            n.count = '0; n.presc = '0; n.halt = 1'b0;
        end else if (enable && !s.halt) begin
            if (int'(s.presc) < int'(s.pscl)) begin
                n.presc = s.presc + 1'b1;
            end else begin
                n.presc = '0;
                if (s.count != s.period) begin
                    next_cnt = int'(s.count) + 1;
                    n.count  = W'(next_cnt);
                    n.exp    = (next_cnt == int'(s.period));
                end else if (s.oneshot) begin
                    n.halt = 1'b1;
                end else begin
                    n.count = '0;
                    n.exp   = (s.period == 0);
                end
            end
        end
        if (n.exp)        n.irq = 1'b1;
        else if (irq_ack) n.irq = 1'b0;
        return n;
    endfunction

    always @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) m <= rst_state();
        else               m <= step(m);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("cmp_count", 32'(count), 32'(m.count));
        chk("cmp_at_terminal", 32'(at_terminal), 32'(m.count == m.period));
        chk("cmp_expired", 32'(expired), 32'(m.exp));
        chk("cmp_irq", 32'(irq), 32'(m.irq));
        chk("cmp_running", 32'(running), 32'(!m.halt));
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic load(input int p, input int ps, input bit os, input bit clr_too, input bit ack_too);
        cfg_load = 1'b1; cfg_period = W'(p); cfg_prescale = PW'(ps); cfg_oneshot = os;
        clear = clr_too; irq_ack = ack_too;
        cyc();
        cfg_load = 1'b0; clear = 1'b0; irq_ack = 1'b0;
    endtask

    int seq2 [5] = '{0, 0, 1, 1, 2};
    int seq3 [6] = '{0, 0, 1, 1, 2, 2};
    int res3 [7] = '{3, 3, 4, 4, 5, 5, 0};

    initial begin
        repeat (2) cyc();
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_running", 32'(running), 1);
        chk("rst_expired", 32'(expired), 0);
        chk("rst_irq", 32'(irq), 0);
        chk("rst_at_terminal", 32'(at_terminal), 0);

        // Defaults: 0,1,2,3 repeating, terminal/expired at 3
        @(negedge clk);
        async_nreset = 1'b1; enable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            chk("dflt_count", 32'(count), 32'(i % 4));
            chk("dflt_expired", 32'(expired), 32'(i % 4 == 3));
            chk("dflt_at_terminal", 32'(at_terminal), 32'(i % 4 == 3));
            chk("dflt_irq", 32'(irq), 32'(i >= 3));
            cyc();
        end

        // One-shot, period 2, prescale 1
        load(2, 1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            chk("os_count", 32'(count), 32'(i < 5 ? seq2[i] : 2));
            chk("os_expired", 32'(expired), 32'(i == 4));
            chk("os_running", 32'(running), 32'(i <= 5));
            cyc();
        end
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        chk("clr_count", 32'(count), 0);
        chk("clr_running", 32'(running), 1);

        // Periodic period 5, freeze mid-prescale
        load(5, 1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            chk("frz_count", 32'(count), 32'(seq3[i]));
            if (i < 5) cyc();
        end
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("frz_hold", 32'(count), 2);
        end
        enable = 1'b1;
        for (int i = 0; i < 7; i++) begin
            cyc();
            chk("frz_resume", 32'(count), 32'(res3[i]));
            chk("frz_expired", 32'(expired), 32'(i == 4));
        end

        // irq set and ack on the same edge: set wins
        load(1, 0, 1'b0, 1'b0, 1'b1);
        chk("ack_irq0", 32'(irq), 0);
        irq_ack = 1'b1;
        cyc();
        irq_ack = 1'b0;
        chk("ack_same_edge_expired", 32'(expired), 1);
        chk("ack_same_edge_irq", 32'(irq), 1);
        irq_ack = 1'b1;
        cyc();
        irq_ack = 1'b0;
        chk("ack_lone_irq", 32'(irq), 0);

        // cfg_load beats clear
        load(7, 0, 1'b0, 1'b1, 1'b0);
        chk("ldclr_count", 32'(count), 0);
        chk("ldclr_expired", 32'(expired), 0);
        repeat (7) cyc();
        chk("ldclr_count7", 32'(count), 7);
        chk("ldclr_expired7", 32'(expired), 1);

        // Full-range period wraps without carry
        load(255, 0, 1'b0, 1'b0, 1'b0);
        repeat (255) cyc();
        chk("max_count", 32'(count), 255);
        chk("max_expired", 32'(expired), 1);
        cyc();
        chk("max_wrap", 32'(count), 0);
        chk("max_expired_off", 32'(expired), 0);

        // Async reset mid-prescale at count 4
        load(9, 2, 1'b0, 1'b0, 1'b0);
        repeat (13) cyc();
        chk("pre_rst_count", 32'(count), 4);
        #2 async_nreset = 1'b0;
        #1;
        chk("arst_count", 32'(count), 0);
        chk("arst_expired", 32'(expired), 0);
        chk("arst_irq", 32'(irq), 0);
        chk("arst_running", 32'(running), 1);
        chk("arst_at_terminal", 32'(at_terminal), 0);
        @(negedge clk);
        async_nreset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("post_rst_count", 32'(count), 32'(i));
            chk("post_rst_expired", 32'(expired), 32'(i == 3));
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prog_timer.md
Name: prog_timer

Overview:
- Parametrised programmable interval timer; successor to the fixed 4-cycle timer.
- Adds runtime-loadable period and prescaler, periodic/one-shot modes, a one-cycle expiry pulse and a sticky interrupt flag with acknowledge.
- Sits beside control FSMs that need second/millisecond ticks.
- Counter and prescaler state are held in instances of the team's `register` module (ctrl NONE/INCR/LOAD/CLR).

Parameters:
- WIDTH, 32, main counter and period width.
- PRESCALE_WIDTH, 16, prescaler counter width.
- DEFAULT_PERIOD, 3, period_reg value after reset; must be < 2^WIDTH.
- DEFAULT_ONESHOT, 0, mode_reg value after reset.

Ports:
- clk  in  1  system clock, rising edge.
- async_nreset  in  1  asynchronous active-low reset.
- enable  in  1  count-enable level; freezes counter and prescaler when low.
- clear  in  1  restart: count and prescaler to 0, leave HALT.
- cfg_load  in  1  one-cycle strobe; load configuration and restart.
- cfg_period  in  WIDTH  terminal count to load.
- cfg_prescale  in  PRESCALE_WIDTH  prescale divisor minus 1 to load.
- cfg_oneshot  in  1  mode to load: 1 = one-shot, 0 = periodic.
- irq_ack  in  1  clears irq.
- count  out  WIDTH  current counter value (registered).
- at_terminal  out  1  combinational level, count == period_reg.
- expired  out  1  registered one-cycle pulse.
- irq  out  1  sticky flag.
- running  out  1  high when state == COUNT.

Behaviour:
- Clock and reset: one clock; reset is asynchronous, active-low, on async_nreset.
- Reset values:
  - count = 0, presc_cnt = 0.
  - period_reg = DEFAULT_PERIOD, prescale_reg = 0, mode_reg = DEFAULT_ONESHOT.
  - state = COUNT.
  - expired = 0, irq = 0, running = 1.
- Reset asserted mid-operation returns all state to these values immediately, with no pending pulse.
- Per-edge priority: cfg_load > clear > tick processing.
- cfg_load:
  - Loads period_reg, prescale_reg and mode_reg.
  - Sets count = 0, presc_cnt = 0, state = COUNT.
  - expired = 0 on that edge.
- clear:
  - Sets count = 0, presc_cnt = 0, state = COUNT, expired = 0.
  - Config registers are unchanged.
  - Ignored when cfg_load is also high.
- Prescaler:
  - Active only when enable = 1 and state = COUNT.
  - presc_cnt counts 0..prescale_reg.
  - tick = active && presc_cnt == prescale_reg; on tick, presc_cnt wraps to 0.
  - prescale_reg = 0 gives a tick every enabled cycle.
- On tick, if count != period_reg: count += 1.
- On tick, if count == period_reg:
  - Periodic mode: count wraps to 0.
  - One-shot mode: count holds and state goes to HALT.
- expired is set to 1 on an edge where a tick makes next count == period_reg.
  - Periodic with period_reg = 0: every tick pulses expired.
  - One-shot HALT transition: no additional pulse.
  - Otherwise expired = 0; width is exactly one cycle.
- Timing: expired rises in the same cycle count first equals period_reg, which is the first cycle at_terminal is high.
- States:
  - COUNT (running = 1).
  - HALT: count frozen at period_reg, at_terminal = 1, prescaler frozen.
  - HALT exits only via clear or cfg_load.
- irq:
  - Set on the edge where expired is set.
  - Cleared by irq_ack.
  - Simultaneous set and ack: set wins.
- Wrap-around:
  - count never exceeds period_reg, because a period change always restarts the count.
  - period_reg = 2^WIDTH-1 is legal; the wrap goes to 0 with no carry out.
- enable low: all counters hold; config and clear still act.
- Default configuration, enable held high:
  - count sequence 0,1,2,3,0,...
  - at_terminal high one cycle in four.

Decomposition:
- Package timer_pkg:
  - Register ctrl constants NONE=2'd0, INCR=2'd1, LOAD=2'd2, CLR=2'd3.
  - State encoding COUNT=1'b0, HALT=1'b1.
- Sub-modules: reuse `register` for count (WIDTH) and presc_cnt (PRESCALE_WIDTH).
  - Ctrl selection uses combinational always blocks, one per counter.
- period_reg, prescale_reg, mode_reg, state, expired and irq are plain flops in prog_timer.
- No new sub-module.

Test Plan:
- Reset, then enable = 1 for 12 cycles, defaults:
  - count = 0,1,2,3,0,1,2,3,0,1,2,3.
  - expired and at_terminal high at count = 3 (cycles 4, 8, 12).
  - irq rises at cycle 4.
- cfg_load with period = 2, prescale = 1, oneshot = 1, then enable high:
  - count steps every 2 cycles: 0,0,1,1,2.
  - expired pulses once at the first count = 2.
  - running drops to 0; count stays 2 for 10+ cycles.
  - clear returns count = 0, running = 1.
- Periodic, period = 5, toggle enable low at count = 2 for 3 cycles: count holds 2 and presc_cnt holds; resumes 3,4,5,0.
- irq set and irq_ack asserted on the same edge as a new expired → irq stays 1; a lone irq_ack next cycle → irq = 0.
- cfg_load and clear in the same cycle, with cfg_period = 7 → period_reg = 7, count = 0, expired = 0; clear has no extra effect.
- Assert async_nreset low asynchronously at mid-prescale count = 4:
  - All outputs go to reset values before the next edge.
  - period_reg returns to 3.
  - After release, the first expired arrives 4 enabled cycles later.
